// File: rtl/quotient_table_loader.sv
// quotient_table_loader
// Streams narrow beats in over valid/ready, packs them little-endian into
// full-width rows and writes each completed row to the quotient table with a
// single-cycle wen/waddr/wdata strobe. Raises done after the last row.
//
// Optional feature macro: QUOTIENT_TABLE_LOADER_CHECKSUM_EN
//   defined   -> checksum is the running XOR of every accepted beat
//   undefined -> no checksum register, checksum output tied to zero
module quotient_table_loader #(
  parameter int IN_WIDTH_BITS    = 5,
  parameter int WDATA_WIDTH_BITS = 6,
  parameter int WADDR_WIDTH      = 1
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              start,
  input  logic                              abort,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [(1<<IN_WIDTH_BITS)-1:0]     in_data,
  output logic                              wen,
  output logic [WADDR_WIDTH-1:0]            waddr,
  output logic [(1<<WDATA_WIDTH_BITS)-1:0]  wdata,
  output logic                              busy,
  output logic                              done,
  output logic [(1<<IN_WIDTH_BITS)-1:0]     checksum
);

  localparam int W      = 1 << IN_WIDTH_BITS;
  localparam int DW     = 1 << WDATA_WIDTH_BITS;
  localparam int LOG_B  = WDATA_WIDTH_BITS - IN_WIDTH_BITS;
  localparam int BEATS  = 1 << LOG_B;
  // A one-bit beat counter is kept even when a row is a single beat.
  localparam int BEAT_W = (LOG_B > 0) ? LOG_B : 1;

  localparam logic [BEAT_W-1:0]      BEAT_LAST = BEAT_W'(BEATS - 1);
  localparam logic [BEAT_W-1:0]      BEAT_ZERO = {BEAT_W{1'b0}};
  localparam logic [WADDR_WIDTH-1:0] ROW_LAST  = {WADDR_WIDTH{1'b1}};
  localparam logic [WADDR_WIDTH-1:0] ROW_ZERO  = {WADDR_WIDTH{1'b0}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [WADDR_WIDTH-1:0]   row_q,   row_d;
  logic [BEAT_W-1:0]        beat_q,  beat_d;
  logic [DW-1:0]            pack_q,  pack_d;
  logic [WADDR_WIDTH-1:0]   waddr_q, waddr_d;
  logic [DW-1:0]            wdata_q, wdata_d;

  // Outputs are pure decodes of the state register or register copies.
  assign in_ready = (state_q == S_FILL);
  assign wen      = (state_q == S_WRITE);
  assign busy     = (state_q == S_FILL) || (state_q == S_WRITE);
  assign done     = (state_q == S_DONE);
  assign waddr    = waddr_q;
  assign wdata    = wdata_q;

  // Next-state, counter and packing logic; abort overrides every other move.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    beat_d  = beat_q;
    pack_d  = pack_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_FILL;
          row_d   = ROW_ZERO;
          beat_d  = BEAT_ZERO;
        end else begin
          state_d = state_q;
        end
      end
      S_FILL: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (in_valid) begin
          for (int b = 0; b < BEATS; b++) begin
            if (beat_q == BEAT_W'(b)) begin
              pack_d[b*W +: W] = in_data;
            end else begin
              pack_d[b*W +: W] = pack_q[b*W +: W];
            end
          end
          if (beat_q == BEAT_LAST) begin
            // Row complete: capture the write port contents for the WRITE cycle.
            beat_d  = BEAT_ZERO;
            state_d = S_WRITE;
            waddr_d = row_q;
            wdata_d = pack_d;
          end else begin
            beat_d  = beat_q + BEAT_W'(1);
          end
        end else begin
          state_d = S_FILL;
        end
      end
      S_WRITE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (row_q == ROW_LAST) begin
          state_d = S_DONE;
        end else begin
          row_d   = row_q + WADDR_WIDTH'(1);
          state_d = S_FILL;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      row_q   <= ROW_ZERO;
      beat_q  <= BEAT_ZERO;
      pack_q  <= {DW{1'b0}};
      waddr_q <= ROW_ZERO;
      wdata_q <= {DW{1'b0}};
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      beat_q  <= beat_d;
      pack_q  <= pack_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

`ifdef QUOTIENT_TABLE_LOADER_CHECKSUM_EN
  logic [W-1:0] sum_q, sum_d;

  // Running XOR of accepted beats, cleared whenever a fresh load starts.
  always_comb begin
    sum_d = sum_q;
    if (((state_q == S_IDLE) || (state_q == S_DONE)) && start) begin
      sum_d = {W{1'b0}};
    end else if ((state_q == S_FILL) && in_valid && !abort) begin
      sum_d = sum_q ^ in_data;
    end else begin
      sum_d = sum_q;
    end
  end

  // Checksum register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sum_q <= {W{1'b0}};
    end else begin
      sum_q <= sum_d;
    end
  end

  assign checksum = sum_q;
`else
  assign checksum = {W{1'b0}};
`endif

endmodule

// File: tb/tb_quotient_table_loader.sv
// Directed self-checking bench for quotient_table_loader (default parameters:
// 32-bit beats, 64-bit rows, 2 rows).
module tb_quotient_table_loader;

  logic        clock;
  logic        reset;
  logic        start;
  logic        abort;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        wen;
  logic [0:0]  waddr;
  logic [63:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] checksum;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_sum;

  quotient_table_loader dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .abort    (abort),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .wen      (wen),
    .waddr    (waddr),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .checksum (checksum)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stream input, clock it, then check the control outputs.
  task automatic tick(input logic v, input logic [31:0] d,
                      input logic e_rdy, input logic e_wen,
                      input logic e_busy, input logic e_done, input string tag);
    in_valid = v;
    in_data  = d;
    @(posedge clock);
    #1;
    chk({tag, "/in_ready"}, {63'd0, in_ready}, {63'd0, e_rdy});
    chk({tag, "/wen"},      {63'd0, wen},      {63'd0, e_wen});
    chk({tag, "/busy"},     {63'd0, busy},     {63'd0, e_busy});
    chk({tag, "/done"},     {63'd0, done},     {63'd0, e_done});
  endtask

  task automatic chk_write(input logic e_addr, input logic [63:0] e_data, input string tag);
    chk({tag, "/waddr"}, {63'd0, waddr}, {63'd0, e_addr});
    chk({tag, "/wdata"}, wdata, e_data);
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    abort    = 1'b0;
    in_valid = 1'b0;
    in_data  = 32'h0000_0000;
    @(posedge clock);
    @(posedge clock);
    #1;
    chk("reset/in_ready", {63'd0, in_ready}, 64'd0);
    chk("reset/wen",      {63'd0, wen},      64'd0);
    chk("reset/busy",     {63'd0, busy},     64'd0);
    chk("reset/done",     {63'd0, done},     64'd0);
    chk("reset/waddr",    {63'd0, waddr},    64'd0);
    chk("reset/wdata",    wdata,             64'd0);
    chk("reset/checksum", {32'd0, checksum}, 64'd0);
    reset = 1'b0;
    tick(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, "idle");

    // Load 1: in_valid held high.
    start = 1'b1;
    tick(1'b1, 32'h0302_0100, 1'b1, 1'b0, 1'b1, 1'b0, "l1_start");
    start = 1'b0;
    tick(1'b1, 32'h0302_0100, 1'b1, 1'b0, 1'b1, 1'b0, "l1_b0");
    tick(1'b1, 32'h0706_0504, 1'b0, 1'b1, 1'b1, 1'b0, "l1_b1");
    chk_write(1'b0, 64'h0706_0504_0302_0100, "l1_row0");
    tick(1'b1, 32'h0B0A_0908, 1'b1, 1'b0, 1'b1, 1'b0, "l1_w0");
    tick(1'b1, 32'h0B0A_0908, 1'b1, 1'b0, 1'b1, 1'b0, "l1_b2");
    tick(1'b1, 32'h0F0E_0D0C, 1'b0, 1'b1, 1'b1, 1'b0, "l1_b3");
    chk_write(1'b1, 64'h0F0E_0D0C_0B0A_0908, "l1_row1");
    tick(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, "l1_done");
`ifdef QUOTIENT_TABLE_LOADER_CHECKSUM_EN
    exp_sum = 32'h0302_0100 ^ 32'h0706_0504 ^ 32'h0B0A_0908 ^ 32'h0F0E_0D0C;
`else
    exp_sum = 32'h0000_0000;
`endif
    chk("l1/checksum", {32'd0, checksum}, {32'd0, exp_sum});
    tick(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, "l1_hold");
    chk_write(1'b1, 64'h0F0E_0D0C_0B0A_0908, "l1_hold");

    // Load 2: same data, in_valid toggling; junk on idle beats must be ignored.
    start = 1'b1;
    tick(1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1, 1'b0, "l2_start");
    start = 1'b0;
    tick(1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1, 1'b0, "l2_gap0");
    tick(1'b1, 32'h0302_0100, 1'b1, 1'b0, 1'b1, 1'b0, "l2_b0");
    tick(1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1, 1'b0, "l2_gap1");
    tick(1'b1, 32'h0706_0504, 1'b0, 1'b1, 1'b1, 1'b0, "l2_b1");
    chk_write(1'b0, 64'h0706_0504_0302_0100, "l2_row0");
    tick(1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1, 1'b0, "l2_w0");
    tick(1'b1, 32'h0B0A_0908, 1'b1, 1'b0, 1'b1, 1'b0, "l2_b2");
    tick(1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1, 1'b0, "l2_gap2");
    tick(1'b1, 32'h0F0E_0D0C, 1'b0, 1'b1, 1'b1, 1'b0, "l2_b3");
    chk_write(1'b1, 64'h0F0E_0D0C_0B0A_0908, "l2_row1");
    tick(1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 1'b1, "l2_done");

    // Abort after the first beat of row 0: no write, back to IDLE.
    start = 1'b1;
    tick(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, "ab_start");
    start = 1'b0;
    tick(1'b1, 32'hAAAA_5555, 1'b1, 1'b0, 1'b1, 1'b0, "ab_b0");
    abort = 1'b1;
    tick(1'b1, 32'hBBBB_6666, 1'b0, 1'b0, 1'b0, 1'b0, "ab_idle");
    abort = 1'b0;
    tick(1'b1, 32'hCCCC_7777, 1'b0, 1'b0, 1'b0, 1'b0, "ab_stay");

    // Reload from IDLE with new data; start pulsed while busy is ignored.
    start = 1'b1;
    tick(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, "rl_start");
    start = 1'b0;
    tick(1'b1, 32'h1122_3344, 1'b1, 1'b0, 1'b1, 1'b0, "rl_b0");
    start = 1'b1;
    tick(1'b1, 32'h5566_7788, 1'b0, 1'b1, 1'b1, 1'b0, "rl_b1_st");
    chk_write(1'b0, 64'h5566_7788_1122_3344, "rl_row0");
    tick(1'b1, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, "rl_w0_st");
    start = 1'b0;
    tick(1'b1, 32'h99AA_BBCC, 1'b1, 1'b0, 1'b1, 1'b0, "rl_b2");
    tick(1'b1, 32'hDDEE_FF00, 1'b0, 1'b1, 1'b1, 1'b0, "rl_b3");
    chk_write(1'b1, 64'hDDEE_FF00_99AA_BBCC, "rl_row1");
    tick(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, "rl_done");
`ifdef QUOTIENT_TABLE_LOADER_CHECKSUM_EN
    exp_sum = 32'h1122_3344 ^ 32'h5566_7788 ^ 32'h99AA_BBCC ^ 32'hDDEE_FF00;
`else
    exp_sum = 32'h0000_0000;
`endif
    chk("rl/checksum", {32'd0, checksum}, {32'd0, exp_sum});

    // From DONE load a third data set; reset asynchronously during row-0 WRITE.
    start = 1'b1;
    tick(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, "rs_start");
    start = 1'b0;
    tick(1'b1, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b1, 1'b0, "rs_b0");
    tick(1'b1, 32'h1234_5678, 1'b0, 1'b1, 1'b1, 1'b0, "rs_b1");
    chk_write(1'b0, 64'h1234_5678_CAFE_F00D, "rs_row0");
    #2;
    reset = 1'b1;
    #1;
    chk("rs/in_ready", {63'd0, in_ready}, 64'd0);
    chk("rs/wen",      {63'd0, wen},      64'd0);
    chk("rs/busy",     {63'd0, busy},     64'd0);
    chk("rs/done",     {63'd0, done},     64'd0);
    chk("rs/waddr",    {63'd0, waddr},    64'd0);
    chk("rs/wdata",    wdata,             64'd0);
    chk("rs/checksum", {32'd0, checksum}, 64'd0);
    tick(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, "rs_held");
    reset = 1'b0;
    tick(1'b1, 32'h5A5A_5A5A, 1'b0, 1'b0, 1'b0, 1'b0, "rs_after1");
    tick(1'b1, 32'hA5A5_A5A5, 1'b0, 1'b0, 1'b0, 1'b0, "rs_after2");
    tick(1'b1, 32'h0F0F_0F0F, 1'b0, 1'b0, 1'b0, 1'b0, "rs_after3");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
